// File: rtl/diag_func_master.sv
// KL10 diagnostic function bus initiator: setup/strobe/hold sequencing of DIAG codes.
// Optional EBUS odd parity generation/checking under DIAG_EBUS_PARITY_EN.
module diag_func_master #(
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned STROBE_CYC = 4,
   parameter int unsigned HOLD_CYC   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [0:6]  cmd_func,
   input  logic [0:35] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [0:35] rsp_data,
   output logic        rsp_err,
   output logic [0:6]  DIAG_DIAG,
   output logic        DIAG_STROBE,
   output logic        DIAG_READ,
   output logic        ebus_drive,
   output logic [0:35] ebus_out,
   input  logic [0:35] ebus_in,
   output logic        ebus_par_out,
   input  logic        ebus_par_in
);

   localparam int unsigned MAX_AB = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int unsigned MAX_C  = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
   localparam int unsigned CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_RESP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          cnt_done;
   logic          is_load;
   logic          par_load;
   logic          par_err;

   assign cnt_done = (cnt == '0);
   assign is_load  = ~cmd_func[0] & cmd_func[1];

`ifdef DIAG_EBUS_PARITY_EN
   // Odd parity bit: set when the data word has an even number of ones.
   assign par_load = is_load & ~^cmd_data;
   assign par_err  = (~^ebus_in) ^ ebus_par_in;
`else
   logic unused_par_in;
   assign unused_par_in = ebus_par_in;
   assign par_load      = 1'b0;
   assign par_err       = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         cmd_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
         DIAG_DIAG    <= '0;
         DIAG_STROBE  <= 1'b0;
         DIAG_READ    <= 1'b0;
         ebus_drive   <= 1'b0;
         ebus_out     <= '0;
         ebus_par_out <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  state        <= S_SETUP;
                  cnt          <= SETUP_LD;
                  cmd_ready    <= 1'b0;
                  rsp_data     <= '0;
                  rsp_err      <= 1'b0;
                  DIAG_DIAG    <= cmd_func;
                  DIAG_READ    <= cmd_func[0];
                  ebus_drive   <= is_load;
                  ebus_out     <= is_load ? cmd_data : '0;
                  ebus_par_out <= par_load;
               end
            end
            S_SETUP: begin
               if (cnt_done) begin
                  state       <= S_STROBE;
                  cnt         <= STROBE_LD;
                  DIAG_STROBE <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_STROBE: begin
               if (cnt_done) begin
                  state       <= S_HOLD;
                  cnt         <= HOLD_LD;
                  DIAG_STROBE <= 1'b0;
                  // Last strobe cycle is the EBUS sampling point for reads.
                  if (DIAG_READ) begin
                     rsp_data <= ebus_in;
                     rsp_err  <= par_err;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_HOLD: begin
               if (cnt_done) begin
                  state        <= S_RESP;
                  cnt          <= '0;
                  rsp_valid    <= 1'b1;
                  DIAG_DIAG    <= '0;
                  DIAG_READ    <= 1'b0;
                  ebus_drive   <= 1'b0;
                  ebus_out     <= '0;
                  ebus_par_out <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_diag_func_master.sv
// Directed bench for diag_func_master: default timing instance plus a 1/1/1 timing instance.
// Parity expectations follow DIAG_EBUS_PARITY_EN.
module tb_diag_func_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
   logic [0:6]  cmd_func, DIAG_DIAG;
   logic [0:35] cmd_data, rsp_data, ebus_out, ebus_in;
   logic        DIAG_STROBE, DIAG_READ, ebus_drive, ebus_par_out, ebus_par_in;

   logic        c1_valid, c1_ready, r1_valid, r1_ready, r1_err;
   logic [0:6]  c1_func, d1_diag;
   logic [0:35] c1_data, r1_data, e1_out, e1_in;
   logic        d1_strobe, d1_read, e1_drive, e1_par_out, e1_par_in;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [0:35] data;
      logic        err;
   } rsp_t;
   rsp_t sb[$];

   always #5 clk = ~clk;

   diag_func_master dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_func(cmd_func), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .DIAG_DIAG(DIAG_DIAG), .DIAG_STROBE(DIAG_STROBE), .DIAG_READ(DIAG_READ),
      .ebus_drive(ebus_drive), .ebus_out(ebus_out), .ebus_in(ebus_in),
      .ebus_par_out(ebus_par_out), .ebus_par_in(ebus_par_in)
   );

   diag_func_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(c1_valid), .cmd_ready(c1_ready),
      .cmd_func(c1_func), .cmd_data(c1_data),
      .rsp_valid(r1_valid), .rsp_ready(r1_ready),
      .rsp_data(r1_data), .rsp_err(r1_err),
      .DIAG_DIAG(d1_diag), .DIAG_STROBE(d1_strobe), .DIAG_READ(d1_read),
      .ebus_drive(e1_drive), .ebus_out(e1_out), .ebus_in(e1_in),
      .ebus_par_out(e1_par_out), .ebus_par_in(e1_par_in)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic odd_par(input logic [0:35] d);
      return ~^d;
   endfunction

   // Issue one command; check every cycle of the bus sequence and the response.
   task automatic run_cmd(input logic [0:6] f, input logic [0:35] d,
                          input logic [0:35] ein, input logic pin, input int delay);
      logic        rd, ld, ex_par;
      logic [0:35] ex_out;
      rsp_t        e, got;
      rd     = f[0];
      ld     = (f[0:1] == 2'b01);
      ex_out = ld ? d : 36'o0;
`ifdef DIAG_EBUS_PARITY_EN
      ex_par = ld ? odd_par(d) : 1'b0;
      e.err  = rd ? (odd_par(ein) != pin) : 1'b0;
`else
      ex_par = 1'b0;
      e.err  = 1'b0;
`endif
      e.data = rd ? ein : 36'o0;
      chk($sformatf("ready_f%o", f), {63'd0, cmd_ready}, 64'd1);
      cmd_valid = 1'b1;
      cmd_func  = f;
      cmd_data  = d;
      tick();
      sb.push_back(e);
      cmd_valid = 1'b0;
      cmd_func  = ~f;
      cmd_data  = ~d;
      for (int c = 1; c <= 8; c++) begin
         if (c == 3) begin
            ebus_in     = ein;
            ebus_par_in = pin;
         end
         if (c == 7) begin
            ebus_in     = ~ein;
            ebus_par_in = ~pin;
         end
         chk($sformatf("bus_f%o_c%0d", f, c),
             {15'd0, DIAG_DIAG, DIAG_STROBE, DIAG_READ, ebus_drive, ebus_out,
              ebus_par_out, cmd_ready, rsp_valid},
             {15'd0, f, (c >= 3 && c <= 6), rd, ld, ex_out, ex_par, 1'b0, 1'b0});
         tick();
      end
      ebus_in     = 36'o0;
      ebus_par_in = 1'b0;
      for (int w = 0; w < delay; w++) begin
         chk($sformatf("wait_f%o_w%0d", f, w),
             {15'd0, DIAG_DIAG, DIAG_STROBE, DIAG_READ, ebus_drive, ebus_out,
              ebus_par_out, cmd_ready, rsp_valid},
             {15'd0, 7'o0, 1'b0, 1'b0, 1'b0, 36'o0, 1'b0, 1'b0, 1'b1});
         chk($sformatf("hold_data_f%o_w%0d", f, w), {27'd0, rsp_err, rsp_data},
             {27'd0, e.err, e.data});
         tick();
      end
      rsp_ready = 1'b1;
      chk($sformatf("rsp_valid_f%o", f), {63'd0, rsp_valid}, 64'd1);
      chk($sformatf("idle_bus_f%o", f),
          {16'd0, DIAG_DIAG, DIAG_STROBE, DIAG_READ, ebus_drive, ebus_out,
           ebus_par_out, cmd_ready},
          64'd0);
      if (rsp_valid && sb.size() > 0) begin
         got = sb.pop_front();
         chk($sformatf("rsp_f%o", f), {27'd0, rsp_err, rsp_data},
             {27'd0, got.err, got.data});
      end else begin
         chk($sformatf("sb_f%o", f), {63'd0, rsp_valid}, 64'd1);
      end
      tick();
      rsp_ready = 1'b0;
      chk($sformatf("post_f%o", f), {62'd0, cmd_ready, rsp_valid}, {62'd0, 1'b1, 1'b0});
   endtask

   initial begin
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_func    = 7'o0;
      cmd_data    = 36'o0;
      rsp_ready   = 1'b0;
      ebus_in     = 36'o0;
      ebus_par_in = 1'b0;
      c1_valid    = 1'b0;
      c1_func     = 7'o0;
      c1_data     = 36'o0;
      r1_ready    = 1'b1;
      e1_in       = 36'o0;
      e1_par_in   = 1'b0;
      tick();
      tick();
      chk("reset_bus",
          {16'd0, DIAG_DIAG, DIAG_STROBE, DIAG_READ, ebus_drive, ebus_out,
           ebus_par_out, rsp_valid},
          64'd0);
      rst_n = 1'b1;
      tick();
      chk("reset_ready", {63'd0, cmd_ready}, 64'd1);

      // Reset asserted in the middle of the strobe phase.
      cmd_valid = 1'b1;
      cmd_func  = 7'o045;
      cmd_data  = 36'o777777_777777;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("mid_strobe", {62'd0, DIAG_STROBE, ebus_drive}, {62'd0, 1'b1, 1'b1});
      rst_n = 1'b0;
      #1;
      chk("rst_async", {62'd0, DIAG_STROBE, ebus_drive}, 64'd0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         chk($sformatf("rst_discard_c%0d", c), {62'd0, cmd_ready, rsp_valid},
             {62'd0, 1'b1, 1'b0});
      end

      run_cmd(7'o071, 36'o123456_701234, 36'o0, 1'b0, 0);
      run_cmd(7'o120, 36'o0, 36'o777000_000777, 1'b0, 0);
      run_cmd(7'o001, 36'o555555_555555, 36'o0, 1'b0, 5);
      run_cmd(7'o177, 36'o0, 36'o1, 1'b1, 0);
      run_cmd(7'o177, 36'o0, 36'o1, 1'b0, 1);
      run_cmd(7'o040, 36'o3, 36'o0, 1'b0, 0);
      run_cmd(7'o100, 36'o0, 36'o3, 1'b1, 2);

      // 1/1/1 timing: single-cycle strobe, response in cycle 4.
      c1_valid = 1'b1;
      c1_func  = 7'o050;
      c1_data  = 36'o000000_000007;
      tick();
      c1_valid = 1'b0;
      chk("t1_c1", {60'd0, d1_strobe, e1_drive, r1_valid, c1_ready}, {60'd0, 4'b0100});
      tick();
      chk("t1_c2", {60'd0, d1_strobe, e1_drive, r1_valid, c1_ready}, {60'd0, 4'b1100});
      tick();
      chk("t1_c3", {60'd0, d1_strobe, e1_drive, r1_valid, c1_ready}, {60'd0, 4'b0100});
      tick();
      chk("t1_c4", {60'd0, d1_strobe, e1_drive, r1_valid, c1_ready}, {60'd0, 4'b0010});
      chk("t1_rsp", {27'd0, r1_err, r1_data}, 64'd0);
      tick();
      chk("t1_c5", {62'd0, r1_valid, c1_ready}, {62'd0, 2'b01});

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/diag_func_master.md
Name: diag_func_master

Overview:
- Front-end-side initiator for the KL10 diagnostic function bus. It is the issuing end of the diag function code, strobe and read lines that the CTL board decodes into its DIAG_* controls.
- Accepts one function request at a time from the console/DTE logic.
- Sequences the function code through setup, strobe and hold phases, and drives the EBUS data for load functions.
- Samples the EBUS for read functions and returns one response per command.

Parameters:
- SETUP_CYC, 2, cycles the function code/data are stable before strobe (≥1)
- STROBE_CYC, 4, cycles DIAG_STROBE is asserted (≥1)
- HOLD_CYC, 2, cycles the code/data are held after strobe deasserts (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- cmd_valid  in  1  request present
- cmd_ready  out  1  block can accept a request
- cmd_func  in  [0:6]  diag function code, octal 000–177
- cmd_data  in  [0:35]  data for load functions
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  [0:35]  EBUS sample for reads; 0 otherwise
- rsp_err  out  1  parity error on read (optional feature only)
- DIAG_DIAG  out  [0:6]  function code to KL
- DIAG_STROBE  out  1  function strobe
- DIAG_READ  out  1  read-class function in progress
- ebus_drive  out  1  master drives EBUS data
- ebus_out  out  [0:35]  EBUS data driven
- ebus_in  in  [0:35]  EBUS data received
- ebus_par_out  out  1  EBUS parity driven
- ebus_par_in  in  1  EBUS parity received

Behaviour:
- Function class is taken from the code:
  - func[0]=1 → READ (100–177)
  - func[0:1]=01 → LOAD (040–077)
  - func[0:1]=00 → CTL (000–037), no data
- States: IDLE, SETUP, STROBE, HOLD, RESP. One cycle counter is reloaded on each state entry.
- IDLE:
  - cmd_ready=1, all bus outputs 0.
  - cmd_valid&cmd_ready latches func/data and moves to SETUP.
  - cmd_ready is 0 in every other state; no pipelining.
- SETUP (SETUP_CYC cycles):
  - DIAG_DIAG = latched func.
  - DIAG_READ=1 for READ.
  - ebus_drive=1 and ebus_out=data for LOAD; ebus_out=0 otherwise.
- STROBE (STROBE_CYC cycles):
  - As SETUP, plus DIAG_STROBE=1.
  - READ: ebus_in is registered into rsp_data on the last STROBE cycle.
- HOLD (HOLD_CYC cycles): as SETUP with DIAG_STROBE=0.
- RESP:
  - All bus outputs return to 0 on entry; rsp_valid=1.
  - rsp_data/rsp_err stay stable until rsp_valid&rsp_ready, then IDLE.
  - rsp_ready held high gives a single-cycle RESP.
- Latency: with the accept at cycle 0, rsp_valid rises at cycle SETUP_CYC+STROBE_CYC+HOLD_CYC+1. With defaults that is 9.
- Next accept is possible the cycle after the response handshake. With rsp_ready held high, the back-to-back period is 10 cycles at defaults.
- CTL and LOAD responses carry rsp_data=0 and rsp_err=0.
- DIAG_STROBE is never asserted unless DIAG_DIAG and ebus_out have been stable for at least SETUP_CYC cycles.
- All outputs are registered. No combinational path from ebus_in to any output.
- Reset (any time, including mid-strobe):
  - Immediately forces IDLE and clears all outputs.
  - cmd_ready=1 after deassert. Any in-flight command is discarded with no response.
- cmd_func/cmd_data changing while not in IDLE have no effect.

Optional Feature:
- Macro: DIAG_EBUS_PARITY_EN.
- Defined:
  - ebus_par_out = odd parity of ebus_out while ebus_drive=1; 0 otherwise.
  - READ: on the sampling cycle, the odd parity of ebus_in is compared with ebus_par_in. Mismatch gives rsp_err=1 in the response.
- Undefined:
  - ebus_par_out is tied to 0 and rsp_err to 0.
  - ebus_par_in is ignored.
- Ports are identical in both builds.

Test Plan:
1. Reset with rst_n low while mid-STROBE → DIAG_STROBE=0, ebus_drive=0 the same cycle; after release cmd_ready=1 and no rsp_valid.
2. LOAD func 071, data 36'o123456_701234, defaults:
   - DIAG_DIAG=071 and ebus_drive=1 on cycles 1–8.
   - DIAG_STROBE only on cycles 3–6.
   - rsp_valid at cycle 9 with rsp_data=0.
3. READ func 120, ebus_in=36'o777000_000777 during strobe → DIAG_READ=1 and ebus_drive=0 throughout; rsp_data=36'o777000_000777 at cycle 9.
4. CTL func 001 followed by a second command with rsp_ready held low 5 cycles:
   - rsp_valid and rsp_data stay stable and cmd_ready stays 0.
   - Second command is accepted the cycle after the handshake.
5. Parameters SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1 → strobe lasts exactly 1 cycle; rsp_valid at cycle 4.
6. With DIAG_EBUS_PARITY_EN defined:
   - READ with ebus_in=36'o1 and ebus_par_in=1 → rsp_err=1.
   - Same read with ebus_par_in=0 → rsp_err=0.
   - LOAD data 36'o3 → ebus_par_out=1.
